// File: rtl/ysyx_22041412_lsu.sv
// Load/store unit: aligns sub-word accesses onto an 8-byte req/gnt/rvalid bus
// and returns one registered write-back beat per instruction.
module ysyx_22041412_lsu #(
  parameter logic [6:0] OPC_LOAD  = 7'b0000011,
  parameter logic [6:0] OPC_STORE = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_func3,
  input  logic [63:0] in_result,
  input  logic [63:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_exc
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        func3_q, func3_d;
  logic [2:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_q, wen_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              out_wen_q, out_wen_d;
  logic              out_exc_q, out_exc_d;

  logic              is_ld_c, is_st_c, bad_f3_c, misal_c;
  logic [STRB_W-1:0] size_mask_c;
  logic [XLEN-1:0]   ld_shift_c, ld_val_c;

  // Decode of the incoming beat: access class, legality and byte-lane mask
  always_comb begin
    is_ld_c  = (in_opcode == OPC_LOAD);
    is_st_c  = (in_opcode == OPC_STORE);
    bad_f3_c = (is_ld_c && (in_func3 == 3'b111)) || (is_st_c && in_func3[2]);
    misal_c  = 1'b0;
    size_mask_c = 8'h01;
    case (in_func3[1:0])
      2'b00: begin misal_c = 1'b0;              size_mask_c = 8'h01; end
      2'b01: begin misal_c = in_result[0];      size_mask_c = 8'h03; end
      2'b10: begin misal_c = |in_result[1:0];   size_mask_c = 8'h0F; end
      default: begin misal_c = |in_result[2:0]; size_mask_c = 8'hFF; end
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured offset/width
  always_comb begin
    ld_shift_c = mem_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  ld_val_c = {{56{ld_shift_c[7]}},  ld_shift_c[7:0]};
      3'b001:  ld_val_c = {{48{ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'b010:  ld_val_c = {{32{ld_shift_c[31]}}, ld_shift_c[31:0]};
      3'b011:  ld_val_c = ld_shift_c;
      3'b100:  ld_val_c = {56'd0, ld_shift_c[7:0]};
      3'b101:  ld_val_c = {48'd0, ld_shift_c[15:0]};
      3'b110:  ld_val_c = {32'd0, ld_shift_c[31:0]};
      default: ld_val_c = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    func3_d     = func3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    out_exc_d   = out_exc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          is_load_d = is_ld_c;
          func3_d   = in_func3;
          off_d     = in_result[2:0];
          rd_d      = in_rd;
          wen_d     = in_wen;
          if (!is_ld_c && !is_st_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_result;
            out_rd_d    = in_rd;
            out_wen_d   = in_wen;
            out_exc_d   = 1'b0;
            state_d     = DONE;
          end else if (bad_f3_c || misal_c) begin
            // Faulting address is returned as data for the trap handler
            out_valid_d = 1'b1;
            out_data_d  = in_result;
            out_rd_d    = in_rd;
            out_wen_d   = 1'b0;
            out_exc_d   = 1'b1;
            state_d     = DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_st_c;
            mem_addr_d  = {in_result[63:3], 3'b000};
            mem_wdata_d = is_st_c ? (in_store_data << {in_result[2:0], 3'b000}) : '0;
            mem_wmask_d = is_st_c ? STRB_W'(size_mask_c << in_result[2:0]) : '0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wmask_d = '0;
          if (is_load_q) begin
            state_d = WAIT;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_rd_d    = rd_q;
            out_wen_d   = 1'b0;
            out_exc_d   = 1'b0;
            state_d     = DONE;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          out_valid_d = 1'b1;
          out_data_d  = ld_val_c;
          out_rd_d    = rd_q;
          out_wen_d   = wen_q;
          out_exc_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      func3_q     <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      out_exc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      out_exc_q   <= out_exc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
  assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Bench for ysyx_22041412_lsu: vector table with a bus responder and a
// write-back scoreboard, plus reset-during-WAIT and stray-response sequences.
module tb_ysyx_22041412_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [63:0] in_result, in_store_data;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen, out_exc;

  ysyx_22041412_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_func3(in_func3),
    .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd), .in_wen(in_wen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wen(out_wen), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] AL = 7'b0110011;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] rdata;
    int          gw;      // REQ cycles before gnt
    int          rw;      // WAIT cycles before rvalid
    int          bw;      // cycles out_ready held low
    logic        mem;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        chk_data;
    logic [63:0] data;
    logic        owen;
    logic        exc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_out_wen"}, 64'(out_wen), 64'd0);
    chk({tag, "_out_exc"}, 64'(out_exc), 64'd0);
  endtask

  // Drive one beat, play memory, then check and retire the WB beat
  task automatic run(input vec_t v);
    vec_t        e;
    logic [63:0] d0;
    exp_q.push_back(v);
    chk("in_ready_pre", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_opcode = v.opc; in_func3 = v.f3; in_result = v.res;
    in_store_data = v.sd; in_rd = v.rd; in_wen = v.wen;
    @(negedge clk);
    in_valid = 1'b0; in_opcode = '0; in_result = '0; in_store_data = '0;
    if (v.mem) begin
      chk("mem_req", 64'(mem_req), 64'd1);
      chk("mem_we", 64'(mem_we), 64'(v.we));
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_wdata", mem_wdata, v.wdata);
      chk("mem_wmask", 64'(mem_wmask), 64'(v.wmask));
      for (int i = 0; i < v.gw; i++) begin
        @(negedge clk);
        chk("mem_req_hold", 64'(mem_req), 64'd1);
        chk("mem_addr_hold", mem_addr, v.addr);
        chk("mem_wdata_hold", mem_wdata, v.wdata);
        chk("mem_wmask_hold", 64'(mem_wmask), 64'(v.wmask));
      end
      chk("out_valid_early_req", 64'(out_valid), 64'd0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      if (!v.we) begin
        chk("mem_req_wait", 64'(mem_req), 64'd0);
        for (int i = 0; i < v.rw; i++) @(negedge clk);
        chk("out_valid_early_wait", 64'(out_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      end
    end else begin
      chk("mem_req_none", 64'(mem_req), 64'd0);
    end
    chk("out_valid_latency", 64'(out_valid), 64'd1);
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    d0 = out_data;
    for (int i = 0; i < v.bw; i++) begin
      @(negedge clk);
      chk("out_valid_hold", 64'(out_valid), 64'd1);
      chk("out_data_hold", out_data, d0);
      chk("in_ready_hold", 64'(in_ready), 64'd0);
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      if (e.chk_data) chk("out_data", out_data, e.data);
      chk("out_rd", 64'(out_rd), 64'(e.rd));
      chk("out_wen", 64'(out_wen), 64'(e.owen));
      chk("out_exc", 64'(out_exc), 64'(e.exc));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_post", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_func3 = '0; in_result = '0;
    in_store_data = '0; in_rd = '0; in_wen = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; out_ready = 1'b0;

    //          opc f3      res                     sd                      rd     wen   rdata                   gw rw bw mem we  addr                    wdata                   wmask  cd   data                    owen exc
    vecs.push_back('{AL, 3'b000, 64'h1234,              64'h0,                  5'd5,  1'b1, 64'h0,                  0, 0, 0, 1'b0, 1'b0, 64'h0,              64'h0,                  8'h00, 1'b1, 64'h1234,              1'b1, 1'b0});
    vecs.push_back('{LD, 3'b000, 64'h8000_0003,         64'h0,                  5'd7,  1'b1, 64'h0000_0000_8000_0000, 0, 0, 0, 1'b1, 1'b0, 64'h8000_0000,      64'h0,                  8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0});
    vecs.push_back('{LD, 3'b110, 64'h8000_0004,         64'h0,                  5'd8,  1'b1, 64'hDEAD_BEEF_0000_0000, 3, 1, 0, 1'b1, 1'b0, 64'h8000_0000,      64'h0,                  8'h00, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back('{ST, 3'b001, 64'h8000_0006,         64'hABCD,               5'd0,  1'b1, 64'h0,                  0, 0, 0, 1'b1, 1'b1, 64'h8000_0000,      64'hABCD_0000_0000_0000, 8'hC0, 1'b0, 64'h0,                  1'b0, 1'b0});
    vecs.push_back('{ST, 3'b010, 64'h8000_0002,         64'h1,                  5'd0,  1'b1, 64'h0,                  0, 0, 0, 1'b0, 1'b0, 64'h0,              64'h0,                  8'h00, 1'b0, 64'h0,                  1'b0, 1'b1});
    vecs.push_back('{LD, 3'b011, 64'h8000_0001,         64'h0,                  5'd9,  1'b1, 64'h0,                  0, 0, 0, 1'b0, 1'b0, 64'h0,              64'h0,                  8'h00, 1'b0, 64'h0,                  1'b0, 1'b1});
    vecs.push_back('{LD, 3'b111, 64'h8000_0000,         64'h0,                  5'd10, 1'b1, 64'h0,                  0, 0, 0, 1'b0, 1'b0, 64'h0,              64'h0,                  8'h00, 1'b0, 64'h0,                  1'b0, 1'b1});
    vecs.push_back('{ST, 3'b100, 64'h8000_0000,         64'h0,                  5'd0,  1'b0, 64'h0,                  0, 0, 0, 1'b0, 1'b0, 64'h0,              64'h0,                  8'h00, 1'b0, 64'h0,                  1'b0, 1'b1});
    vecs.push_back('{LD, 3'b011, 64'h8000_0008,         64'h0,                  5'd11, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 0, 4, 1'b1, 1'b0, 64'h8000_0008,      64'h0,                  8'h00, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0});
    vecs.push_back('{LD, 3'b001, 64'h8000_0002,         64'h0,                  5'd12, 1'b1, 64'h0000_0000_8001_0000, 1, 0, 0, 1'b1, 1'b0, 64'h8000_0000,      64'h0,                  8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0});
    vecs.push_back('{LD, 3'b101, 64'h8000_0006,         64'h0,                  5'd13, 1'b1, 64'hF00D_0000_0000_0000, 0, 2, 0, 1'b1, 1'b0, 64'h8000_0000,      64'h0,                  8'h00, 1'b1, 64'h0000_0000_0000_F00D, 1'b1, 1'b0});
    vecs.push_back('{LD, 3'b010, 64'h8000_0004,         64'h0,                  5'd14, 1'b1, 64'h8765_4321_0000_0000, 0, 0, 0, 1'b1, 1'b0, 64'h8000_0000,      64'h0,                  8'h00, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0});
    vecs.push_back('{LD, 3'b100, 64'h8000_0007,         64'h0,                  5'd15, 1'b0, 64'hA500_0000_0000_0000, 0, 0, 0, 1'b1, 1'b0, 64'h8000_0000,      64'h0,                  8'h00, 1'b1, 64'h0000_0000_0000_00A5, 1'b0, 1'b0});
    vecs.push_back('{ST, 3'b000, 64'h8000_0005,         64'h1122_3344_5566_77EE, 5'd0, 1'b0, 64'h0,                  0, 0, 0, 1'b1, 1'b1, 64'h8000_0000,      64'h6677_EE00_0000_0000, 8'h20, 1'b0, 64'h0,                  1'b0, 1'b0});
    vecs.push_back('{ST, 3'b011, 64'h8000_0010,         64'hCAFE_BABE_1234_5678, 5'd0, 1'b0, 64'h0,                  2, 0, 1, 1'b1, 1'b1, 64'h8000_0010,      64'hCAFE_BABE_1234_5678, 8'hFF, 1'b0, 64'h0,                  1'b0, 1'b0});
    vecs.push_back('{ST, 3'b010, 64'h8000_0004,         64'h0000_0000_DEAD_BEEF, 5'd0, 1'b0, 64'h0,                  0, 0, 0, 1'b1, 1'b1, 64'h8000_0000,      64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 64'h0,                  1'b0, 1'b0});
    vecs.push_back('{AL, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  5'd31, 1'b0, 64'h0,                  0, 0, 2, 1'b0, 1'b0, 64'h0,              64'h0,                  8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Stray bus responses while idle must be ignored
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("stray_idle_out_valid", 64'(out_valid), 64'd0);
    chk("stray_idle_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run(vecs[i]);

    // Reset asserted while a load waits for rvalid
    in_valid = 1'b1; in_opcode = LD; in_func3 = 3'b011; in_result = 64'h8000_0020;
    in_rd = 5'd3; in_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_seq_mem_addr", mem_addr, 64'h8000_0020);
    chk("rst_seq_req_low", 64'(mem_req), 64'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("post_reset_rvalid_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Unit recovers and handles a normal beat afterwards
    run(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
